nvdla_glb_intr_ctrl: RTL and testbench
======================================

NVDLA_GLB_INTR_CTRL -- requirements
Module: nvdla_glb_intr_ctrl

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 16, range 0-255: minimum deassert gap of core_intr after a clear.
REQ-002 SHALL have port nvdla_core_clk, input, 1: clock for all flops.
REQ-003 SHALL have port nvdla_core_rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port src_done, input, 12: one-cycle done pulses from the units.
  Bit order [0..11] = sdp0, sdp1, cdp0, cdp1, pdp0, pdp1, cdma_dat0, cdma_dat1, cdma_wt0, cdma_wt1, cacc0, cacc1.
REQ-005 SHALL have port intr_mask, input, 12: per-source mask from the GLB register file; 1 = masked. Same bit order as src_done.
REQ-006 SHALL have port set_trigger, input, 1: one-cycle pulse, INTR_SET register written.
REQ-007 SHALL have port status_trigger, input, 1: one-cycle pulse, INTR_STATUS register written.
REQ-008 SHALL have port reg_wr_data, input, 32: CSB write data, valid when a trigger is high.
REQ-009 SHALL have port intr_status, output, 12: status flops; drives both the STATUS and SET readback fields.
REQ-010 SHALL have port core_intr, output, 1: registered, level interrupt to the host.

Function
REQ-011 SHALL map reg_wr_data to the 12 sources as follows: bits[5:0] to sources 0-5; bits[21:16] to sources 6-11; all other bits ignored.
REQ-012 SHALL set status bit i on the next clock edge when src_done[i]=1 or (set_trigger=1 and mapped wr bit i=1).
REQ-013 SHALL clear status bit i on the next clock edge when status_trigger=1 and mapped wr bit i=1 (write-1-to-clear); a written 0 leaves the bit unchanged.
REQ-014 SHALL let set win over clear for the same bit in the same cycle, so a hardware event is never lost.
REQ-015 SHALL compute pending = OR over i of (intr_status[i] AND NOT intr_mask[i]); the mask SHALL NOT gate status capture.
REQ-016 SHALL implement an FSM with states IDLE, ASSERT and HOLDOFF; core_intr = 1 only in ASSERT.
REQ-017 SHALL transition IDLE->ASSERT when pending=1, and ASSERT->HOLDOFF when pending=0.
  In HOLDOFF an 8-bit counter is loaded with HOLDOFF_CYCLES-1 and decrements each cycle.
  HOLDOFF->IDLE occurs when the counter is 0; pending SHALL be ignored while in HOLDOFF.
REQ-018 SHALL transition ASSERT->IDLE directly when HOLDOFF_CYCLES=0.
REQ-019 SHALL meet the following latency: src_done pulse at edge N sets status at N+1 and raises core_intr at N+2 when unmasked and in IDLE.
REQ-020 SHALL handle a mask change while in ASSERT that drives pending to 0 like a clear, i.e. it enters HOLDOFF.
REQ-021 SHALL treat simultaneous set_trigger and status_trigger per bit as in REQ-014.

Reset
REQ-022 SHALL, when nvdla_core_rstn is low, asynchronously force intr_status=0, core_intr=0, FSM=IDLE and counter=0, including mid-HOLDOFF.
REQ-023 SHALL ignore src_done pulses coincident with an active reset.

Configuration
REQ-024 SHALL compile the HOLDOFF state and counter only when macro NVDLA_GLB_INTR_HOLDOFF_EN is defined.
REQ-025 SHALL, without NVDLA_GLB_INTR_HOLDOFF_EN, remove the counter, make ASSERT->IDLE direct, and ignore HOLDOFF_CYCLES.

Structure
REQ-026 SHALL place NUM_SRC=12, the source index constants, the wr-data bit-position table and the FSM state enum in package nvdla_glb_intr_pkg.
REQ-027 SHALL implement each status bit in sub-module nvdla_glb_intr_status_bit (set/W1C flop with set priority), instantiated NUM_SRC times.

Verification
REQ-028 SHALL verify: src_done[4] pulse, mask=0 -> intr_status=0x010 at N+1, core_intr=1 at N+2.
REQ-029 SHALL verify: status=0x001, status_trigger with wr=0x00000001 -> status=0, core_intr low one cycle later.
  With the macro defined and HOLDOFF_CYCLES=16, a new unmasked event SHALL NOT raise core_intr for 16 cycles.
REQ-030 SHALL verify: set_trigger with wr=0x00300000 -> intr_status=0xC00 (cacc0/1), core_intr=1 two cycles later.
REQ-031 SHALL verify: src_done[0] pulse coincident with status_trigger wr=0x1 -> status bit 0 remains 1.
REQ-032 SHALL verify: intr_mask=0xFFF, src_done=0xFFF -> intr_status=0xFFF, core_intr stays 0.
  Then mask=0x000 -> core_intr=1 one cycle later.
REQ-033 SHALL verify: reset asserted during HOLDOFF with status=0x3F -> status=0, core_intr=0, FSM=IDLE immediately.

Source files
------------

// File: rtl/nvdla_glb_intr_pkg.sv
// Shared constants, types and helpers for the global interrupt controller.
// Holds source indices, the write-data bit map and the FSM state type.
package nvdla_glb_intr_pkg;

  localparam int NUM_SRC = 12;

  localparam int SRC_SDP0      = 0;
  localparam int SRC_SDP1      = 1;
  localparam int SRC_CDP0      = 2;
  localparam int SRC_CDP1      = 3;
  localparam int SRC_PDP0      = 4;
  localparam int SRC_PDP1      = 5;
  localparam int SRC_CDMA_DAT0 = 6;
  localparam int SRC_CDMA_DAT1 = 7;
  localparam int SRC_CDMA_WT0  = 8;
  localparam int SRC_CDMA_WT1  = 9;
  localparam int SRC_CACC0     = 10;
  localparam int SRC_CACC1     = 11;

  localparam int WR_POS [NUM_SRC] = '{
    0, 1, 2, 3, 4, 5,
    16, 17, 18, 19, 20, 21
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } intr_state_e;

  function automatic logic [NUM_SRC-1:0] wr_to_src(
    input logic [31:0] wr
  );
    logic [NUM_SRC-1:0] m;
    for (int i = 0; i < NUM_SRC; i++) begin
      m[i] = wr[WR_POS[i]];
    end
    return m;
  endfunction

endpackage

// File: rtl/nvdla_glb_intr_status_bit.sv
// One interrupt status flop: set or write-1-to-clear, set has priority.
// Ports: nvdla_core_clk/nvdla_core_rstn, set, clr in; q status out.
module nvdla_glb_intr_status_bit (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/nvdla_glb_intr_ctrl.sv
// Global interrupt controller: 12 status bits, mask, level core_intr.
// Ports: src_done/intr_mask/set_trigger/status_trigger/reg_wr_data in;
// intr_status, core_intr out. Holdoff gap needs NVDLA_GLB_INTR_HOLDOFF_EN.
module nvdla_glb_intr_ctrl
  import nvdla_glb_intr_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic [NUM_SRC-1:0]  src_done,
  input  logic [NUM_SRC-1:0]  intr_mask,
  input  logic                set_trigger,
  input  logic                status_trigger,
  input  logic [31:0]         reg_wr_data,
  output logic [NUM_SRC-1:0]  intr_status,
  output logic                core_intr
);

  logic [NUM_SRC-1:0] wr_map;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               pending;

  intr_state_e state;
  intr_state_e state_nxt;

  assign wr_map  = wr_to_src(reg_wr_data);
  assign set_vec = src_done
                 | ({NUM_SRC{set_trigger}} & wr_map);
  assign clr_vec = {NUM_SRC{status_trigger}} & wr_map;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_bit
    nvdla_glb_intr_status_bit u_bit (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .set             (set_vec[i]),
      .clr             (clr_vec[i]),
      .q               (intr_status[i])
    );
  end

  // Mask only gates the output, never capture.
  assign pending = |(intr_status & ~intr_mask);

`ifdef NVDLA_GLB_INTR_HOLDOFF_EN
  localparam logic [7:0] HOLD_INIT =
    (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!pending) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_HOLDOFF;
            cnt_nxt   = HOLD_INIT;
          end
        end
      end
      ST_HOLDOFF: begin
        // pending is deliberately ignored here
        if (cnt == 8'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) cnt <= 8'd0;
    else                  cnt <= cnt_nxt;
  end
`else
  logic [7:0] unused_holdoff;
  assign unused_holdoff = 8'(HOLDOFF_CYCLES);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!pending) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= ST_IDLE;
      core_intr <= 1'b0;
    end else begin
      state     <= state_nxt;
      core_intr <= (state_nxt == ST_ASSERT);
    end
  end

endmodule

// File: tb/tb_nvdla_glb_intr_ctrl.sv
// Randomized scoreboard bench for nvdla_glb_intr_ctrl.
// Driver pushes model predictions; monitor pops after each edge.
module tb_nvdla_glb_intr_ctrl;

  localparam int HC = 16;
`ifdef NVDLA_GLB_INTR_HOLDOFF_EN
  localparam int HGAP = HC;
`else
  localparam int HGAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] src_done = '0;
  logic [11:0] intr_mask = '0;
  logic        set_trigger = 1'b0;
  logic        status_trigger = 1'b0;
  logic [31:0] reg_wr_data = '0;
  logic [11:0] intr_status;
  logic        core_intr;

  int checks = 0;
  int failures = 0;

  logic [12:0] exp_q[$];

  logic [11:0] m_status = '0;
  logic        m_core = 1'b0;
  int          m_hold = 0;

  always #5 clk = ~clk;

  nvdla_glb_intr_ctrl #(.HOLDOFF_CYCLES(HC)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .src_done        (src_done),
    .intr_mask       (intr_mask),
    .set_trigger     (set_trigger),
    .status_trigger  (status_trigger),
    .reg_wr_data     (reg_wr_data),
    .intr_status     (intr_status),
    .core_intr       (core_intr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] map_wr(input logic [31:0] w);
    return {w[21:16], w[5:0]};
  endfunction

  task automatic cyc(input logic [11:0] done, input logic [11:0] mask,
                     input logic st, input logic tt,
                     input logic [31:0] wr, input logic rst);
    logic        pend;
    logic [11:0] setm;
    logic [11:0] clrm;
    @(negedge clk);
    src_done       = done;
    intr_mask      = mask;
    set_trigger    = st;
    status_trigger = tt;
    reg_wr_data    = wr;
    if (rst) begin
      if (rstn) begin
        rstn = 1'b0;
        #1;
        chk("async_rst_status", 32'(intr_status), 32'h0);
        chk("async_rst_intr", 32'(core_intr), 32'h0);
      end
      m_status = '0;
      m_core   = 1'b0;
      m_hold   = 0;
    end else begin
      rstn = 1'b1;
      pend = |(m_status & ~mask);
      if (m_hold > 0) begin
        m_hold--;
        m_core = 1'b0;
      end else if (m_core) begin
        if (!pend) begin
          m_core = 1'b0;
          m_hold = HGAP;
        end
      end else begin
        m_core = pend;
      end
      setm = done | (st ? map_wr(wr) : 12'h0);
      clrm = tt ? map_wr(wr) : 12'h0;
      m_status = (m_status & ~clrm) | setm;
    end
    exp_q.push_back({m_status, m_core});
  endtask

  task automatic idle(input int n, input logic [11:0] mask);
    for (int i = 0; i < n; i++) cyc('0, mask, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("intr_status", 32'(intr_status), 32'(e[12:1]));
        chk("core_intr", 32'(core_intr), 32'(e[0]));
      end
    end
  end

  initial begin : driver
    logic [11:0] d;
    logic [11:0] mk;
    logic [31:0] w;
    logic        st;
    logic        tt;
    for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(2, '0);

    cyc(12'h010, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(3, '0);
    cyc('0, '0, 1'b0, 1'b1, 32'h10, 1'b0);
    idle(20, '0);

    cyc(12'h001, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(3, '0);
    cyc('0, '0, 1'b0, 1'b1, 32'h1, 1'b0);
    cyc(12'h002, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(22, '0);

    cyc('0, '0, 1'b1, 1'b0, 32'h0030_0000, 1'b0);
    idle(3, '0);
    cyc('0, '0, 1'b0, 1'b1, 32'h003F_003F, 1'b0);
    idle(20, '0);

    cyc(12'h001, '0, 1'b0, 1'b1, 32'h1, 1'b0);
    idle(2, '0);
    cyc('0, '0, 1'b1, 1'b1, 32'h0001_0001, 1'b0);
    idle(2, '0);
    cyc('0, '0, 1'b0, 1'b1, 32'h003F_003F, 1'b0);
    idle(20, '0);

    cyc(12'hFFF, 12'hFFF, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 12'hFFF);
    idle(3, 12'h000);
    idle(2, 12'hFFF);
    cyc('0, '0, 1'b0, 1'b1, 32'h003F_003F, 1'b0);
    idle(20, '0);

    cyc('0, '0, 1'b1, 1'b0, 32'h0000_003F, 1'b0);
    idle(3, '0);
    cyc('0, '0, 1'b0, 1'b1, 32'h0000_003F, 1'b0);
    idle(3, '0);
    cyc(12'h001, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc(12'h001, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(2, '0);
    cyc(12'h020, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(3, '0);

    mk = '0;
    for (int i = 0; i < 500; i++) begin
      d  = ($urandom_range(0, 5) == 0) ? 12'(1 << $urandom_range(0, 11))
                                       : 12'h0;
      st = ($urandom_range(0, 9) == 0);
      tt = ($urandom_range(0, 4) == 0);
      w  = $urandom;
      if ($urandom_range(0, 15) == 0) mk = 12'($urandom);
      cyc(d, mk, st, tt, w, ($urandom_range(0, 99) == 0));
    end
    idle(2, mk);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
